original_vs_simplified: RTL and testbench

Four-input Boolean function block that computes F(A,B,C,D) = Σm(0,1,2,5,8,9,10) in two forms: the canonical minterm sum-of-products and the K-map-minimized form. It also includes a clocked equivalence monitor that records input coverage and any disagreement between the two forms. It sits in the logic-minimization lab datapath as the reference/optimized pair under comparison.

---
 rtl/original_vs_simplified.sv | 58 +++++
 tb/tb_original_vs_simplified.sv | 124 ++++++++++++
 2 files changed

// File: rtl/original_vs_simplified.sv
// original_vs_simplified: F = sum m(0,1,2,5,8,9,10) as canonical and minimized SOP, plus optional equivalence/coverage monitor
// Ports: clk, rst (async, active-high), sample_en -> monitor capture strobe
//        A,B,C,D -> minterm index {A,B,C,D}, A is MSB
//        orig_F, sim_F -> combinational canonical / simplified F
//        mismatch, cov_map[15:0], cov_done, vec_cnt[7:0] -> monitor outputs
// Macro CHECKER_EN builds the monitor; without it the monitor outputs are tied to 0.
module original_vs_simplified (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_en,
    input  logic        A,
    input  logic        B,
    input  logic        C,
    input  logic        D,
    output logic        orig_F,
    output logic        sim_F,
    output logic        mismatch,
    output logic [15:0] cov_map,
    output logic        cov_done,
    output logic [7:0]  vec_cnt
);
    assign orig_F = (~A & ~B & ~C & ~D) | (~A & ~B & ~C &  D) | (~A & ~B &  C & ~D) |
                    (~A &  B & ~C &  D) | ( A & ~B & ~C & ~D) | ( A & ~B & ~C &  D) |
                    ( A & ~B &  C & ~D);
    assign sim_F = (~B & ~C) | (~B & ~D) | (~A & ~C & D);
`ifdef CHECKER_EN
    logic [15:0] cov_q, cov_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mis_q, mis_d;
    always_comb begin
        cov_d = cov_q | ({15'd0, sample_en} << {A, B, C, D});
        cnt_d = (sample_en && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        mis_d = mis_q | (sample_en & (orig_F ^ sim_F));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cov_q <= '0;
            cnt_q <= '0;
            mis_q <= 1'b0;
        end else begin
            cov_q <= cov_d;
            cnt_q <= cnt_d;
            mis_q <= mis_d;
        end
    end
    assign cov_map  = cov_q;
    assign vec_cnt  = cnt_q;
    assign mismatch = mis_q;
    assign cov_done = &cov_q;
`else
    logic unused_mon;
    assign unused_mon = &{1'b0, clk, rst, sample_en};
    assign cov_map  = '0;
    assign vec_cnt  = '0;
    assign mismatch = 1'b0;
    assign cov_done = 1'b0;
`endif
endmodule

// File: tb/tb_original_vs_simplified.sv
// tb_original_vs_simplified: randomized self-checking bench against a truth-table/coverage model
module tb_original_vs_simplified;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic        A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic        orig_F, sim_F, mismatch, cov_done;
    logic [15:0] cov_map;
    logic [7:0]  vec_cnt;
    int checks = 0;
    int failures = 0;
`ifdef CHECKER_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif
    localparam logic [15:0] TRUTH = 16'h0727;
    logic [15:0] m_cov;
    int          m_cnt;
    logic        m_mis;

    original_vs_simplified dut (
        .clk(clk), .rst(rst), .sample_en(sample_en),
        .A(A), .B(B), .C(C), .D(D),
        .orig_F(orig_F), .sim_F(sim_F),
        .mismatch(mismatch), .cov_map(cov_map), .cov_done(cov_done), .vec_cnt(vec_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_f(input logic [3:0] v);
        check($sformatf("orig_F[%0d]", v), {31'd0, orig_F}, {31'd0, TRUTH[v]});
        check($sformatf("sim_F[%0d]", v), {31'd0, sim_F}, {31'd0, TRUTH[v]});
    endtask

    task automatic check_mon(input string tag);
        check({tag, ".cov_map"}, {16'd0, cov_map}, MON ? {16'd0, m_cov} : 32'd0);
        check({tag, ".cov_done"}, {31'd0, cov_done}, MON ? {31'd0, m_cov == 16'hFFFF} : 32'd0);
        check({tag, ".vec_cnt"}, {24'd0, vec_cnt}, MON ? m_cnt : 32'd0);
        check({tag, ".mismatch"}, {31'd0, mismatch}, MON ? {31'd0, m_mis} : 32'd0);
    endtask

    task automatic cycle(input logic en, input logic [3:0] v, input bit chk_mon);
        @(negedge clk);
        {A, B, C, D} = v;
        sample_en = en;
        #1;
        check_f(v);
        @(posedge clk);
        if (en) begin
            m_cov[v] = 1'b1;
            if (m_cnt < 255) m_cnt++;
            m_mis = m_mis | (TRUTH[v] ^ TRUTH[v]);
        end
        #1;
        if (chk_mon) check_mon("cyc");
    endtask

    task automatic pulse_rst(input logic [3:0] v);
        @(negedge clk);
        sample_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        m_cov = '0;
        m_cnt = 0;
        m_mis = 1'b0;
        check_mon("rst");
        {A, B, C, D} = v;
        #1;
        check_f(v);
        rst = 1'b0;
    endtask

    initial begin
        m_cov = '0;
        m_cnt = 0;
        m_mis = 1'b0;
        #2;
        check_mon("por");
        #10 rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            {A, B, C, D} = 4'(i);
            #50;
            check_f(4'(i));
        end
        check_mon("idle");
        for (int i = 0; i < 16; i++) cycle(1'b1, 4'(i), 1'b1);
        check("sweep.cov_map", {16'd0, cov_map}, MON ? 32'h0000FFFF : 32'd0);
        check("sweep.cov_done", {31'd0, cov_done}, {31'd0, MON});
        check("sweep.vec_cnt", {24'd0, vec_cnt}, MON ? 32'd16 : 32'd0);
        check("sweep.mismatch", {31'd0, mismatch}, 32'd0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'($urandom_range(15)), 1'b1);
        pulse_rst(4'd3);
        cycle(1'b1, 4'd5, 1'b1);
        cycle(1'b0, 4'd7, 1'b1);
        cycle(1'b1, 4'd10, 1'b1);
        cycle(1'b1, 4'd10, 1'b1);
        check("part.cov_map", {16'd0, cov_map}, MON ? 32'h00000420 : 32'd0);
        check("part.cov_done", {31'd0, cov_done}, 32'd0);
        check("part.vec_cnt", {24'd0, vec_cnt}, MON ? 32'd3 : 32'd0);
        pulse_rst(4'd9);
        for (int i = 0; i < 300; i++) cycle(1'b1, 4'd0, i >= 250);
        check("sat.vec_cnt", {24'd0, vec_cnt}, MON ? 32'd255 : 32'd0);
        check("sat.cov_map", {16'd0, cov_map}, MON ? 32'h00000001 : 32'd0);
        cycle(1'b1, 4'd12, 1'b1);
        check("sat.vec_hold", {24'd0, vec_cnt}, MON ? 32'd255 : 32'd0);
        pulse_rst(4'd1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'(i), 1'b1);
        pulse_rst(4'd8);
        check("mid.vec_cnt", {24'd0, vec_cnt}, 32'd0);
        check("mid.cov_map", {16'd0, cov_map}, 32'd0);
        for (int i = 0; i < 400; i++) cycle(1'($urandom_range(1)), 4'($urandom_range(15)), 1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
